// File: rtl/time_tag_checker.sv
// Time tag checker: classifies incoming words as time tags or events, tracks the
// sender's time tag period, forwards events tagged with the period, and counts errors.
module time_tag_checker #(
    parameter int DATA_BITS      = 128,
    parameter int CRC_BITS       = 5,
    parameter int MODULE_ID_BITS = 4,
    parameter int PERIOD_BITS    = 48,
    parameter int ERR_BITS       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MODULE_ID_BITS-1:0] module_id,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_BITS-1:0]      s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_BITS-1:0]      m_data,
    output logic [PERIOD_BITS-1:0]    m_period,
    output logic                      tt_strobe,
    output logic [PERIOD_BITS-1:0]    period,
    output logic                      locked,
    output logic [ERR_BITS-1:0]       err_framing,
    output logic [ERR_BITS-1:0]       err_module,
    output logic [ERR_BITS-1:0]       err_seq
);

    // Word layout: framing mark on top, then the kind bit, the module ID,
    // two spare bits, then a reserved field that must be zero in a time tag.
    localparam int FRAME_LSB = DATA_BITS - CRC_BITS;
    localparam int KIND_BIT  = FRAME_LSB - 1;
    localparam int MOD_MSB   = KIND_BIT - 1;
    localparam int MOD_LSB   = MOD_MSB - MODULE_ID_BITS + 1;
    localparam int RSV_MSB   = MOD_LSB - 3;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [PERIOD_BITS-1:0] period_next;
    logic [PERIOD_BITS-1:0] tag_period;
    logic                   accept;
    logic                   framing_ok, module_ok, is_tag;
    logic                   strobe_next, load_event;
    logic                   inc_framing, inc_module, inc_seq;
    logic                   unused_spare;

    function automatic logic [ERR_BITS-1:0] sat_inc(input logic [ERR_BITS-1:0] v,
                                                    input logic en);
        return (en && v != '1) ? v + 1'b1 : v;
    endfunction

    assign s_ready      = ~m_valid | m_ready;
    assign accept       = s_valid & s_ready;
    assign locked       = (state == LOCKED);
    assign unused_spare = ^s_data[MOD_LSB-1:RSV_MSB+1];

    assign framing_ok = (s_data[DATA_BITS-1:FRAME_LSB] == '1);
    assign module_ok  = (s_data[MOD_MSB:MOD_LSB] == module_id);
    assign is_tag     = ~s_data[KIND_BIT] & ~|s_data[RSV_MSB:PERIOD_BITS];
    assign tag_period = s_data[PERIOD_BITS-1:0];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the if-chain can leave one unassigned and infer a latch.
        state_next  = state;
        period_next = period;
        strobe_next = 1'b0;
        load_event  = 1'b0;
        inc_framing = 1'b0;
        inc_module  = 1'b0;
        inc_seq     = 1'b0;
        if (accept) begin
            if (!framing_ok) begin
                inc_framing = 1'b1;
                state_next  = UNLOCKED;
            end else if (!module_ok) begin
                inc_module = 1'b1;
            end else if (is_tag) begin
                period_next = tag_period;
                strobe_next = 1'b1;
                state_next  = LOCKED;
                // A zero period is the sender restarting, not a sequence break.
                if (state == LOCKED && tag_period != PERIOD_BITS'(period + 1'b1)
                    && tag_period != '0)
                    inc_seq = 1'b1;
            end else if (state == LOCKED) begin
                load_event = 1'b1;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= UNLOCKED;
            period      <= '0;
            tt_strobe   <= 1'b0;
            err_framing <= '0;
            err_module  <= '0;
            err_seq     <= '0;
        end else begin
            state       <= state_next;
            period      <= period_next;
            tt_strobe   <= strobe_next;
            err_framing <= sat_inc(err_framing, inc_framing);
            err_module  <= sat_inc(err_module, inc_module);
            err_seq     <= sat_inc(err_seq, inc_seq);
        end
    end

    // Output register: a new event may replace the one leaving on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_period <= '0;
        end else if (load_event) begin
            m_valid  <= 1'b1;
            m_data   <= s_data;
            m_period <= period;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_time_tag_checker.sv
// Directed bench for time_tag_checker: lock, forwarding, wrap, framing loss,
// backpressure, counter saturation and asynchronous reset.
module tb_time_tag_checker;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   module_id;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic [47:0]  m_period;
    logic         tt_strobe;
    logic [47:0]  period;
    logic         locked;
    logic [15:0]  err_framing, err_module, err_seq;

    int vectors     = 0;
    int miscompares = 0;

    time_tag_checker dut (
        .clk        (clk),
        .rst        (rst),
        .module_id  (module_id),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_period   (m_period),
        .tt_strobe  (tt_strobe),
        .period     (period),
        .locked     (locked),
        .err_framing(err_framing),
        .err_module (err_module),
        .err_seq    (err_seq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_tag(input logic [3:0] mod, input logic [47:0] per);
        return {5'h1F, 1'b0, mod, 2'b00, 1'b0, 67'd0, per};
    endfunction

    function automatic logic [127:0] mk_evt(input logic [3:0] mod, input logic [63:0] pl);
        return {5'h1F, 1'b1, mod, 6'd0, pl, pl[47:0]};
    endfunction

    task automatic send(input logic [127:0] w);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".m_valid"},   m_valid,     0);
        check({tag, ".tt_strobe"}, tt_strobe,   0);
        check({tag, ".locked"},    locked,      0);
        check({tag, ".period"},    period,      0);
        check({tag, ".m_data"},    m_data,      0);
        check({tag, ".m_period"},  m_period,    0);
        check({tag, ".err_frm"},   err_framing, 0);
        check({tag, ".err_mod"},   err_module,  0);
        check({tag, ".err_seq"},   err_seq,     0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [127:0] w, evt_a, evt_b;

    initial begin
        rst       = 1'b1;
        module_id = 4'd3;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();
        check("rst.s_ready", s_ready, 1);

        // Lock on the first tag, then two in-sequence tags
        send(mk_tag(4'd3, 48'd5));
        check("lock.locked", locked, 1);
        check("lock.strobe5", tt_strobe, 1);
        check("lock.period5", period, 5);
        send(mk_tag(4'd3, 48'd6));
        check("lock.strobe6", tt_strobe, 1);
        send(mk_tag(4'd3, 48'd7));
        check("lock.strobe7", tt_strobe, 1);
        check("lock.period7", period, 7);
        @(posedge clk); #1;
        check("lock.strobe_off", tt_strobe, 0);
        check("lock.err_seq", err_seq, 0);
        check("lock.err_frm", err_framing, 0);
        check("lock.err_mod", err_module, 0);

        // Events carry the period in force when accepted
        do_reset();
        send(mk_tag(4'd3, 48'd10));
        evt_a = mk_evt(4'd3, 64'hDEAD_BEEF_0123_4567);
        send(evt_a);
        check("fwd.valid1", m_valid, 1);
        check("fwd.data1", m_data, evt_a);
        check("fwd.per1", m_period, 10);
        send(mk_tag(4'd3, 48'd11));
        check("fwd.drain", m_valid, 0);
        check("fwd.period11", period, 11);
        evt_b = mk_evt(4'd3, 64'h8000_0000_FFFF_0001);
        send(evt_b);
        check("fwd.valid2", m_valid, 1);
        check("fwd.data2", m_data, evt_b);
        check("fwd.per2", m_period, 11);

        // Period wrap, sender-reset resync, then a sequence error
        do_reset();
        send(mk_tag(4'd3, 48'hFFFF_FFFF_FFFF));
        send(mk_tag(4'd3, 48'd0));
        send(mk_tag(4'd3, 48'd1));
        check("wrap.err_seq0", err_seq, 0);
        send(mk_tag(4'd3, 48'd9));
        check("wrap.err_seq1", err_seq, 1);
        check("wrap.period9", period, 9);
        check("wrap.strobe9", tt_strobe, 1);
        check("wrap.locked", locked, 1);

        // Framing error unlocks; a following event is dropped
        w = mk_tag(4'd3, 48'd10);
        w[127:123] = 5'h1E;
        send(w);
        check("frm.err", err_framing, 1);
        check("frm.locked", locked, 0);
        check("frm.strobe", tt_strobe, 0);
        send(mk_evt(4'd3, 64'h1234));
        check("frm.dropped", m_valid, 0);
        check("frm.err_seq", err_seq, 1);

        // Backpressure: held word stays stable, replacement loads with no bubble
        do_reset();
        send(mk_tag(4'd3, 48'd20));
        m_ready = 1'b0;
        evt_a = mk_evt(4'd3, 64'hAAAA_5555_AAAA_5555);
        evt_b = mk_evt(4'd3, 64'h0F0F_F0F0_1357_9BDF);
        send(evt_a);
        check("bp.valid", m_valid, 1);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = evt_b;
        #1;
        check("bp.s_ready", s_ready, 0);
        @(posedge clk); #1;
        check("bp.hold_data", m_data, evt_a);
        check("bp.hold_valid", m_valid, 1);
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.next_valid", m_valid, 1);
        check("bp.next_data", m_data, evt_b);
        check("bp.next_per", m_period, 20);
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk); #1;
        check("bp.drained", m_valid, 0);

        // Module-mismatch counter saturation
        do_reset();
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = mk_tag(4'd5, 48'd1);
        repeat (65535) @(posedge clk);
        #1;
        check("sat.full", err_module, 16'hFFFF);
        repeat (10) @(posedge clk);
        #1;
        check("sat.hold", err_module, 16'hFFFF);
        check("sat.locked", locked, 0);
        check("sat.err_seq", err_seq, 0);
        s_valid = 1'b0;

        // Asynchronous reset mid-stream discards a pending word
        send(mk_tag(4'd3, 48'd1));
        m_ready = 1'b0;
        send(mk_evt(4'd3, 64'h7777));
        check("arst.pending", m_valid, 1);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = mk_tag(4'd5, 48'd2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("arst");
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/time_tag_checker.md
TIME_TAG_CHECKER -- requirements
Module: time_tag_checker

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_BITS, 128, word width.
REQ-002 Parameter CRC_BITS, 5, framing field width (word bits [127:123]).
REQ-003 Parameter MODULE_ID_BITS, 4, module ID width (bits [121:118]).
REQ-004 Parameter PERIOD_BITS, 48, time tag counter width (bits [47:0]).
REQ-005 Parameter ERR_BITS, 16, error counter width.
REQ-006 Port clk  in  1: the single clock; all logic SHALL be on its rising edge.
REQ-007 Port rst  in  1: asynchronous, active-high reset.
REQ-008 Port module_id  in  MODULE_ID_BITS: expected source module; quasi-static.
REQ-009 Port s_valid  in  1: input word valid.
REQ-010 Port s_ready  out  1: input word accepted when s_valid & s_ready.
REQ-011 Port s_data  in  DATA_BITS: input word.
REQ-012 Port m_valid  out  1: forwarded event valid.
REQ-013 Port m_ready  in  1: downstream ready.
REQ-014 Port m_data  out  DATA_BITS: forwarded event word.
REQ-015 Port m_period  out  PERIOD_BITS: time tag period in force when the event was accepted.
REQ-016 Port tt_strobe  out  1: one-cycle pulse per accepted, matching time tag.
REQ-017 Port period  out  PERIOD_BITS: current tracked period.
REQ-018 Port locked  out  1: high in state LOCKED.
REQ-019 Ports err_framing, err_module, err_seq  out  ERR_BITS each: saturating error counters.

Function
REQ-020 The block SHALL hold a one-entry output register, with s_ready = ~m_valid | m_ready (combinational).
REQ-021 On acceptance, framing_ok SHALL be s_data[127:123]==5'h1F.
REQ-022 On acceptance, a word SHALL be a time tag iff framing_ok, bit[122]==0, bit[115]==0 and bits[114:48]==0.
REQ-023 On acceptance, every other framing_ok word SHALL be an event.
REQ-024 Classification priority SHALL be: framing error, then module mismatch (bits[121:118] != module_id), then time tag/event.
REQ-025 Each accepted word SHALL increment at most one error counter, and each counter SHALL saturate at all-ones.
REQ-026 A framing-error word SHALL be dropped, SHALL increment err_framing, and SHALL force UNLOCKED.
REQ-027 A module-mismatch word SHALL be dropped, SHALL increment err_module, and SHALL leave state unchanged.
REQ-028 The FSM SHALL have two states: UNLOCKED (reset state) and LOCKED.
REQ-029 In UNLOCKED, an event SHALL be dropped silently.
REQ-030 In UNLOCKED, a time tag SHALL load period with bits[47:0], pulse tt_strobe, and move to LOCKED.
REQ-031 In LOCKED, a time tag whose period equals period+1 (mod 2^PERIOD_BITS, so all-ones wraps to 0) SHALL be accepted.
REQ-032 In LOCKED, a time tag with period 0 SHALL be accepted as a sender-reset resync without error.
REQ-033 In LOCKED, any other time tag SHALL increment err_seq, and period SHALL adopt the tag value, with the state remaining LOCKED.
REQ-034 Every time tag accepted in LOCKED SHALL update period and pulse tt_strobe.
REQ-035 In LOCKED, an event SHALL be loaded into m_data, with m_period = period at the accepting edge and m_valid set.
REQ-036 Latency SHALL be one cycle: m_valid, tt_strobe, period and the counters update on the edge that accepts the word.
REQ-037 m_valid SHALL clear on m_valid & m_ready unless a new event is accepted on the same edge (back-to-back, no bubble).
REQ-038 m_data and m_period SHALL hold stable while m_valid & ~m_ready.
REQ-039 Time tags and dropped words SHALL NOT occupy the output register and SHALL be accepted whenever s_ready is high.

Reset
REQ-040 While rst is high, outputs SHALL be: m_valid=0, tt_strobe=0, locked=0, period=0, m_data=0, m_period=0, all error counters=0, FSM=UNLOCKED.
REQ-041 Reset SHALL act immediately (asynchronous assertion) and SHALL discard any pending output word.
REQ-042 The first acceptance SHALL occur on the first rising edge after rst deasserts.
REQ-043 Error counters SHALL clear only on rst.

Verification
REQ-044 Scenario: module_id=3; tags with period 5, 6, 7 from module 3, m_ready=1 -> locked=1 after the first tag, three tt_strobe pulses, period=7, all counters 0.
REQ-045 Scenario: locked at period 10; event, tag 11, event -> two m_valid beats with m_period 10 then 11, data bit-exact.
REQ-046 Scenario: locked at 48'hFFFF_FFFF_FFFF; tag 0, tag 1, then tag 9 -> no error across the wrap, err_seq=1 after tag 9, period=9, still locked.
REQ-047 Scenario: locked; word with bits[127:123]=5'h1E, then an event -> err_framing=1, locked=0, event dropped (m_valid stays 0).
REQ-048 Scenario: m_ready=0 with an event held; second event offered -> s_ready=0, m_data stable; m_ready=1 for one cycle -> second event loaded on the same edge, no bubble.
REQ-049 Scenario: err_module preloaded to saturation via 65536 mismatched words -> err_module stays at 16'hFFFF; rst asserted mid-stream -> all outputs zero immediately, before the next clock edge.
